// File: rtl/if_stage.sv
// Instruction-fetch stage: runs a req/ack fetch at the current PC, loads the
// IF/ID register, stalls the PC while a fetch is outstanding, and drains a
// request that was squashed by a branch flush before issuing the next one.
module if_stage #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic        hazard_stall_i,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        fetch_stall_o,
    output logic [31:0] pc4_o,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_inst_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_req_addr;
    logic [31:0] r_buf_inst;
    logic [31:0] r_buf_pc4;
    logic [31:0] r_ifid_inst;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;
    logic [31:0] w_pc4;
    logic        w_deliver;
    logic        w_buffer;

    assign w_pc4 = pc_i + 32'd4;

    // Hand an instruction to IF/ID: a fresh ack, or the buffered word once the
    // hazard clears. A flush always wins and nothing is delivered.
    assign w_deliver = (((r_state == S_FETCH) && mem_ack_i) || (r_state == S_HOLD))
                       && !hazard_stall_i && !flush_i;

    // Ack arrived while ID is stalled: park the word until the hazard clears.
    assign w_buffer = (r_state == S_FETCH) && mem_ack_i && hazard_stall_i && !flush_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and memory/PC handshake outputs.
    always_comb begin
        w_state_nxt   = r_state;
        mem_req_o     = 1'b0;
        mem_addr_o    = r_req_addr;
        // Free the PC on deliver, and on flush so it can take the branch target.
        fetch_stall_o = !(w_deliver || flush_i);
        case (r_state)
            S_IDLE: begin
                fetch_stall_o = 1'b1;
                if (start_i) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req_o  = 1'b1;
                mem_addr_o = pc_i;
                if (flush_i && !mem_ack_i) w_state_nxt = S_DISCARD;
                else if (w_buffer)         w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (flush_i || !hazard_stall_i) w_state_nxt = S_FETCH;
            end
            S_DISCARD: begin
                // Old request must complete at its original address; its data is dropped.
                mem_req_o     = 1'b1;
                mem_addr_o    = r_req_addr;
                fetch_stall_o = 1'b1;
                if (mem_ack_i) w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Track the outstanding request address and buffer a stalled ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req_addr <= 32'd0;
            r_buf_inst <= NOP_INST;
            r_buf_pc4  <= 32'd0;
        end else begin
            if (r_state == S_FETCH) r_req_addr <= pc_i;
            if (w_buffer) begin
                r_buf_inst <= mem_data_i;
                r_buf_pc4  <= w_pc4;
            end
        end
    end

    // IF/ID register: flush > hazard hold > deliver > bubble (pc4 kept on bubble).
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_ifid_valid <= 1'b0;
            r_ifid_inst  <= NOP_INST;
            r_ifid_pc4   <= 32'd0;
        end else if (hazard_stall_i) begin
            r_ifid_valid <= r_ifid_valid;
        end else if (w_deliver) begin
            r_ifid_valid <= 1'b1;
            r_ifid_inst  <= (r_state == S_HOLD) ? r_buf_inst : mem_data_i;
            r_ifid_pc4   <= (r_state == S_HOLD) ? r_buf_pc4  : w_pc4;
        end else begin
            r_ifid_valid <= 1'b0;
            r_ifid_inst  <= NOP_INST;
        end
    end

    assign pc4_o        = w_pc4;
    assign ifid_valid_o = r_ifid_valid;
    assign ifid_inst_o  = r_ifid_inst;
    assign ifid_pc4_o   = r_ifid_pc4;

endmodule
